// File: rtl/vga_box_pkg.sv
// Shared constants, colours and FSM state type for the bouncing-box renderer.
package vga_box_pkg;

    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_NUM_BOXES = 3;
    localparam int unsigned DEF_BOX_SIZE  = 64;
    localparam int unsigned DEF_SPEED_W   = 3;
    localparam int unsigned DEF_BORDER_W  = 2;

    localparam int unsigned COORD_W    = 10;
    localparam int unsigned RGB_W      = 6;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned BOX_X_PAD  = 8;
    localparam int unsigned BOX_Y_STEP = 16;

    localparam logic [RGB_W-1:0] RGB_BLACK  = 6'b000000;
    localparam logic [RGB_W-1:0] RGB_BORDER = 6'b000011;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    // Colour of box by index mod 4, ordered {R,G,B}
    function automatic logic [RGB_W-1:0] box_colour(input logic [1:0] idx);
        case (idx)
            2'd0:    return 6'b111111;
            2'd1:    return 6'b110000;
            2'd2:    return 6'b001100;
            default: return 6'b111100;
        endcase
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// One-axis move/bounce step for a box; used for both x and y.
module vga_box_mover
    import vga_box_pkg::*;
#(
    parameter int unsigned ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned BOX_SIZE = DEF_BOX_SIZE,
    parameter int unsigned SPEED_W  = DEF_SPEED_W
) (
    input  logic [COORD_W-1:0] pos,
    input  logic               dir,
    input  logic [SPEED_W-1:0] speed,
    output logic [COORD_W-1:0] pos_next_c,
    output logic               dir_next_c,
    output logic               bounce_c
);

    localparam int unsigned MAX_POS = ACTIVE - 1 - BOX_SIZE;

    logic [10:0] far_c;

    // 11-bit sums so the far-edge test cannot wrap near the screen edge
    always_comb begin
        pos_next_c = pos;
        dir_next_c = dir;
        bounce_c   = 1'b0;
        far_c      = 11'(pos) + 11'(BOX_SIZE) + 11'(speed);
        if (speed != '0) begin
            if (!dir) begin
                if (far_c >= 11'(ACTIVE - 1)) begin
                    pos_next_c = COORD_W'(MAX_POS);
                    dir_next_c = 1'b1;
                    bounce_c   = 1'b1;
                end else begin
                    pos_next_c = pos + COORD_W'(speed);
                end
            end else begin
                if (11'(pos) < 11'(speed)) begin
                    pos_next_c = '0;
                    dir_next_c = 1'b0;
                    bounce_c   = 1'b1;
                end else begin
                    pos_next_c = pos - COORD_W'(speed);
                end
            end
        end
    end

endmodule

// File: rtl/vga_multi_box.sv
// Several bouncing boxes: per-frame position update FSM plus registered pixel colour.
module vga_multi_box
    import vga_box_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned NUM_BOXES = DEF_NUM_BOXES,
    parameter int unsigned BOX_SIZE  = DEF_BOX_SIZE,
    parameter int unsigned SPEED_W   = DEF_SPEED_W,
    parameter int unsigned BORDER_W  = DEF_BORDER_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               video_active,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic               pause,
    input  logic [SPEED_W-1:0] speed,
    output logic [5:0]         rgb,
    output logic [7:0]         bounce_count,
    output logic               busy
);

    localparam int unsigned IDX_W = 2;

    state_t             state;
    logic [IDX_W-1:0]   index;
    logic [COORD_W-1:0] box_x [NUM_BOXES];
    logic [COORD_W-1:0] box_y [NUM_BOXES];
    logic               box_dx [NUM_BOXES];
    logic               box_dy [NUM_BOXES];

    logic [COORD_W-1:0] sel_x_c, sel_y_c, nx_c, ny_c;
    logic               sel_dx_c, sel_dy_c, ndx_c, ndy_c, bx_c, by_c;
    logic [RGB_W-1:0]   colour_c;

    // Route the box being updated this cycle into the shared movers
    always_comb begin
        sel_x_c  = '0;
        sel_y_c  = '0;
        sel_dx_c = 1'b0;
        sel_dy_c = 1'b0;
        for (int unsigned i = 0; i < NUM_BOXES; i++) begin
            if (index == IDX_W'(i)) begin
                sel_x_c  = box_x[i];
                sel_y_c  = box_y[i];
                sel_dx_c = box_dx[i];
                sel_dy_c = box_dy[i];
            end
        end
    end

    vga_box_mover #(.ACTIVE(H_ACTIVE), .BOX_SIZE(BOX_SIZE), .SPEED_W(SPEED_W)) u_mover_x (
        .pos(sel_x_c), .dir(sel_dx_c), .speed(speed),
        .pos_next_c(nx_c), .dir_next_c(ndx_c), .bounce_c(bx_c)
    );

    vga_box_mover #(.ACTIVE(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .SPEED_W(SPEED_W)) u_mover_y (
        .pos(sel_y_c), .dir(sel_dy_c), .speed(speed),
        .pos_next_c(ny_c), .dir_next_c(ndy_c), .bounce_c(by_c)
    );

    // Update FSM: one box per cycle during vertical blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            index        <= '0;
            busy         <= 1'b0;
            bounce_count <= '0;
            for (int unsigned i = 0; i < NUM_BOXES; i++) begin
                box_x[i]  <= COORD_W'(i * (BOX_SIZE + BOX_X_PAD));
                box_y[i]  <= COORD_W'(i * BOX_Y_STEP);
                box_dx[i] <= 1'(i);
                box_dy[i] <= 1'(i >> 1);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start && !pause) begin
                        state <= UPDATE;
                        busy  <= 1'b1;
                        index <= '0;
                    end
                end
                UPDATE: begin
                    for (int unsigned i = 0; i < NUM_BOXES; i++) begin
                        if (index == IDX_W'(i)) begin
                            box_x[i]  <= nx_c;
                            box_y[i]  <= ny_c;
                            box_dx[i] <= ndx_c;
                            box_dy[i] <= ndy_c;
                        end
                    end
                    if ((bx_c || by_c) && (bounce_count != 8'hFF)) begin
                        bounce_count <= bounce_count + 8'd1;
                    end
                    if (index == IDX_W'(NUM_BOXES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        index <= '0;
                    end else begin
                        index <= index + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel colour: lowest-index box wins, then border, else black
    always_comb begin
        colour_c = RGB_BLACK;
        if ((pix_x < COORD_W'(BORDER_W)) || (11'(pix_x) >= 11'(H_ACTIVE - BORDER_W)) ||
            (pix_y < COORD_W'(BORDER_W)) || (11'(pix_y) >= 11'(V_ACTIVE - BORDER_W))) begin
            colour_c = RGB_BORDER;
        end
        for (int k = int'(NUM_BOXES) - 1; k >= 0; k--) begin
            if ((pix_x >= box_x[k]) && (11'(pix_x) < 11'(box_x[k]) + 11'(BOX_SIZE)) &&
                (pix_y >= box_y[k]) && (11'(pix_y) < 11'(box_y[k]) + 11'(BOX_SIZE))) begin
                colour_c = box_colour(2'(k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= RGB_BLACK;
        end else begin
            rgb <= video_active ? colour_c : RGB_BLACK;
        end
    end

endmodule

// File: tb/tb_vga_multi_box.sv
// Bench for vga_multi_box: default instance plus a small square single-box instance.
module tb_vga_multi_box;

    localparam int NB  = 3;
    localparam int BS  = 64;
    localparam int HA  = 640;
    localparam int VA  = 480;
    localparam int BW  = 2;
    localparam int H2  = 128;
    localparam int BS2 = 15;
    localparam int NV  = 16;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       va;
        logic [5:0] exp;
        logic [5:0] exp2;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, frame_start, video_active, pause;
    logic [9:0] pix_x, pix_y;
    logic [2:0] speed;
    logic [5:0] rgb, rgb2;
    logic [7:0] bc, bc2;
    logic       busy, busy2;

    always #5 clk = ~clk;

    vga_multi_box dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .video_active(video_active),
        .pix_x(pix_x), .pix_y(pix_y), .pause(pause), .speed(speed),
        .rgb(rgb), .bounce_count(bc), .busy(busy)
    );

    vga_multi_box #(.H_ACTIVE(H2), .V_ACTIVE(H2), .NUM_BOXES(1), .BOX_SIZE(BS2),
                    .SPEED_W(3), .BORDER_W(BW)) dut2 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .video_active(video_active),
        .pix_x(pix_x), .pix_y(pix_y), .pause(pause), .speed(speed),
        .rgb(rgb2), .bounce_count(bc2), .busy(busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mx[NB], my[NB], mdx[NB], mdy[NB], mcnt;
    int m2x, m2y, m2dx, m2dy, m2cnt;
    int last_bounces;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference axis step taken straight from the bounce rules
    function automatic void move(input int pos, input int dir, input int spd, input int active,
                                 input int box, output int np, output int nd, output bit b);
        np = pos; nd = dir; b = 1'b0;
        if (spd == 0) return;
        if (dir == 0) begin
            if (pos + box + spd >= active - 1) begin np = active - 1 - box; nd = 1; b = 1'b1; end
            else np = pos + spd;
        end else begin
            if (pos < spd) begin np = 0; nd = 0; b = 1'b1; end
            else np = pos - spd;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i] = i * (BS + 8); my[i] = i * 16; mdx[i] = i & 1; mdy[i] = (i >> 1) & 1;
        end
        mcnt = 0;
        m2x = 0; m2y = 0; m2dx = 0; m2dy = 0; m2cnt = 0;
    endfunction

    function automatic void model_frame(input int spd);
        bit b1, b2;
        int nx, ny, ndx, ndy;
        last_bounces = 0;
        for (int i = 0; i < NB; i++) begin
            move(mx[i], mdx[i], spd, HA, BS, nx, ndx, b1);
            move(my[i], mdy[i], spd, VA, BS, ny, ndy, b2);
            mx[i] = nx; mdx[i] = ndx; my[i] = ny; mdy[i] = ndy;
            if (b1 || b2) begin
                last_bounces++;
                if (mcnt < 255) mcnt++;
            end
        end
        move(m2x, m2dx, spd, H2, BS2, nx, ndx, b1);
        move(m2y, m2dy, spd, H2, BS2, ny, ndy, b2);
        m2x = nx; m2dx = ndx; m2y = ny; m2dy = ndy;
        if ((b1 || b2) && m2cnt < 255) m2cnt++;
    endfunction

    function automatic logic [5:0] colour_of(input int idx);
        case (idx % 4)
            0:       return 6'b111111;
            1:       return 6'b110000;
            2:       return 6'b001100;
            default: return 6'b111100;
        endcase
    endfunction

    function automatic logic [5:0] pix_ref(input int px, input int py, input bit va);
        if (!va) return 6'b000000;
        for (int i = 0; i < NB; i++)
            if (px >= mx[i] && px < mx[i] + BS && py >= my[i] && py < my[i] + BS) return colour_of(i);
        if (px < BW || px >= HA - BW || py < BW || py >= VA - BW) return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic logic [5:0] pix_ref2(input int px, input int py, input bit va);
        if (!va) return 6'b000000;
        if (px >= m2x && px < m2x + BS2 && py >= m2y && py < m2y + BS2) return 6'b111111;
        if (px < BW || px >= H2 - BW || py < BW || py >= H2 - BW) return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic check_state(input string tag);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s x%0d", tag, i), dut.box_x[i], mx[i]);
            check($sformatf("%s y%0d", tag, i), dut.box_y[i], my[i]);
            check($sformatf("%s dx%0d", tag, i), dut.box_dx[i], mdx[i]);
            check($sformatf("%s dy%0d", tag, i), dut.box_dy[i], mdy[i]);
        end
        check({tag, " bounce"}, bc, mcnt);
        check({tag, " b2 pos"}, {dut2.box_x[0], dut2.box_y[0]}, {10'(m2x), 10'(m2y)});
        check({tag, " b2 dir"}, {dut2.box_dx[0], dut2.box_dy[0]}, {1'(m2dx), 1'(m2dy)});
        check({tag, " b2 bounce"}, bc2, m2cnt);
    endtask

    task automatic do_frame(input int spd, input bit pz, input string tag);
        int nb;
        speed = 3'(spd);
        pause = pz;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 20) begin
            nb++;
            step();
        end
        check({tag, " busy_len"}, nb, pz ? 0 : NB);
        if (!pz) model_frame(spd);
        check_state(tag);
    endtask

    initial begin
        bit pre42, pre43, extra;
        int prev_bc2;

        rst_n = 1'b0; frame_start = 1'b0; video_active = 1'b0; pause = 1'b0;
        pix_x = '0; pix_y = '0; speed = '0;
        model_reset();
        step(); step();
        check("reset busy", busy, 0);
        check("reset rgb", rgb, 0);
        check("reset bounce", bc, 0);
        check("reset box1 x", dut.box_x[1], 72);
        check_state("reset");
        rst_n = 1'b1;
        step();

        // First frame after reset at speed 5
        do_frame(5, 1'b0, "f1");
        check("f1 box0 x", dut.box_x[0], 5);
        check("f1 box0 y", dut.box_y[0], 5);
        check("f1 box1 x", dut.box_x[1], 67);

        // Pixel table: fixed points with known colours, then random points from the model
        vecs[0]  = '{10'd0,   10'd0,   1'b1, 6'b000011, 6'b0};
        vecs[1]  = '{10'd67,  10'd30,  1'b1, 6'b111111, 6'b0};
        vecs[2]  = '{10'd67,  10'd30,  1'b0, 6'b000000, 6'b0};
        vecs[3]  = '{10'd639, 10'd479, 1'b1, 6'b000011, 6'b0};
        vecs[4]  = '{10'd320, 10'd240, 1'b1, 6'b000000, 6'b0};
        vecs[5]  = '{10'd5,   10'd5,   1'b1, 6'b111111, 6'b0};
        vecs[6]  = '{10'd68,  10'd5,   1'b1, 6'b111111, 6'b0};
        vecs[7]  = '{10'd69,  10'd5,   1'b1, 6'b000000, 6'b0};
        vecs[8]  = '{10'd67,  10'd21,  1'b1, 6'b111111, 6'b0};
        vecs[9]  = '{10'd130, 10'd21,  1'b1, 6'b110000, 6'b0};
        vecs[10] = '{10'd131, 10'd21,  1'b1, 6'b000000, 6'b0};
        vecs[11] = '{10'd1,   10'd240, 1'b1, 6'b000011, 6'b0};
        for (int i = 12; i < NV; i++) begin
            vecs[i].x  = 10'($urandom_range(0, HA - 1));
            vecs[i].y  = 10'($urandom_range(0, VA - 1));
            vecs[i].va = 1'($urandom_range(0, 1));
            vecs[i].exp = pix_ref(int'(vecs[i].x), int'(vecs[i].y), vecs[i].va);
        end
        for (int i = 0; i < NV; i++)
            vecs[i].exp2 = pix_ref2(int'(vecs[i].x), int'(vecs[i].y), vecs[i].va);
        for (int i = 0; i < NV; i++) begin
            pix_x = vecs[i].x; pix_y = vecs[i].y; video_active = vecs[i].va;
            step();
            check($sformatf("pix%0d rgb", i), rgb, vecs[i].exp);
            check($sformatf("pix%0d rgb2", i), rgb2, vecs[i].exp2);
        end
        video_active = 1'b0;

        // Steady speed 5 until both the right-wall and the corner events have been seen
        pre42 = 1'b0;
        for (int f = 0; f < 300; f++) begin
            pre42 = (mx[0] == 570 && mdx[0] == 0);
            pre43 = (m2x == 2 && m2y == 2 && m2dx == 1 && m2dy == 1);
            prev_bc2 = int'(bc2);
            do_frame(5, 1'b0, "run5");
            if (pre43) begin
                check("corner pos", {dut2.box_x[0], dut2.box_y[0]}, 0);
                check("corner dir", {dut2.box_dx[0], dut2.box_dy[0]}, 0);
                check("corner once", bc2, prev_bc2 + 1);
            end
            if (pre42) begin
                check("wall x", dut.box_x[0], 575);
                check("wall dx", dut.box_dx[0], 1);
                do_frame(5, 1'b0, "wall_next");
                check("wall back x", dut.box_x[0], 570);
                break;
            end
        end

        // Paused frames and zero-speed frames leave everything in place
        for (int f = 0; f < 10; f++) do_frame(5, 1'b1, "pause");
        for (int f = 0; f < 5; f++) do_frame(0, 1'b0, "speed0");

        // Random speeds with occasional pause until the bounce counter saturates
        for (int f = 0; f < 8000 && mcnt < 255; f++)
            do_frame(int'($urandom_range(6, 7)), ($urandom_range(0, 9) == 0), "sat");
        check("sat level", bc, 255);
        extra = 1'b0;
        for (int f = 0; f < 1000 && !extra; f++) begin
            do_frame(7, 1'b0, "sat_more");
            if (last_bounces > 0) extra = 1'b1;
        end
        check("sat hold", bc, 255);

        // Reset asserted while the update pass is in progress
        speed = 3'd5; pause = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("mid busy", busy, 1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid rst busy", busy, 0);
        check("mid rst rgb", rgb, 0);
        check_state("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        check_state("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
